// File: rtl/cram_responder.sv
// Device-side model of a cellular-RAM (PSRAM) pin interface: address-muxed dq,
// configurable wait latency, byte-masked word array and a bus configuration register.
module cram_responder #(
  parameter int unsigned MEM_AW        = 10,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 3,
  parameter logic [15:0] CFG_RESET     = 16'h9D1F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [5:0]  a,
  input  logic        adv_n,
  input  logic        cre,
  input  logic        ce_n,
  input  logic        oe_n,
  input  logic        we_n,
  input  logic        ub_n,
  input  logic        lb_n,
  output logic        wait_out,
  output logic [15:0] cfg_reg
);

  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam int unsigned DEPTH   = 2 ** MEM_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_WAIT, S_RD_DATA, S_WR_WAIT, S_WR_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [21:0]       r_addr;
  logic              r_cre_l;
  logic [15:0]       r_cfg;
  logic [15:0]       r_dq_out;
  logic              r_wait;
  logic [15:0]       r_mem [DEPTH];

  logic              w_latch;
  logic              w_mem_we;
  logic              w_cfg_we;
  logic [MEM_AW-1:0] w_idx;
  logic [15:0]       w_rd_word;
  logic [15:0]       w_rd_masked;
  logic              w_unused;

  assign w_idx       = r_addr[MEM_AW-1:0];
  assign w_rd_word   = r_cre_l ? r_cfg : r_mem[w_idx];
  assign w_rd_masked = {ub_n ? 8'h00 : w_rd_word[15:8], lb_n ? 8'h00 : w_rd_word[7:0]};
  assign w_unused    = &{1'b0, r_addr[21:16]};

  // Next-state, latency counter and write strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_mem_we    = 1'b0;
    w_cfg_we    = 1'b0;
    if (ce_n) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!adv_n) begin
            w_latch     = 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR: begin
          if (!adv_n) begin
            w_latch = 1'b1;
          end else if (!we_n) begin
            w_state_nxt = S_WR_WAIT;
            w_cnt_nxt   = CW'(WRITE_LATENCY);
          end else if (!oe_n) begin
            w_state_nxt = S_RD_WAIT;
            w_cnt_nxt   = CW'(READ_LATENCY);
          end
        end
        S_RD_WAIT: begin
          if (r_cnt > CW'(1)) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RD_DATA;
          end
        end
        S_WR_WAIT: begin
          // Data is sampled in the cycle after the counter expires, once wait has dropped.
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else begin
            w_state_nxt = S_WR_DONE;
            w_cfg_we    = r_cre_l;
            w_mem_we    = ~r_cre_l;
          end
        end
        S_RD_DATA: ;
        S_WR_DONE: ;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_cre_l  <= 1'b0;
      r_cfg    <= CFG_RESET;
      r_dq_out <= '0;
      r_wait   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wait   <= (w_state_nxt == S_RD_WAIT) ||
                  ((w_state_nxt == S_WR_WAIT) && (w_cnt_nxt != '0));
      r_dq_out <= (w_state_nxt == S_RD_DATA) ? w_rd_masked : 16'h0000;
      if (w_latch) begin
        r_addr  <= {a, dq_in};
        r_cre_l <= cre;
      end
      if (w_cfg_we) begin
        r_cfg <= r_addr[15:0];
      end
    end
  end

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      if (!ub_n) r_mem[w_idx][15:8] <= dq_in[15:8];
      if (!lb_n) r_mem[w_idx][7:0]  <= dq_in[7:0];
    end
  end

  assign dq_out   = r_dq_out;
  assign dq_oe    = (r_state == S_RD_DATA) & ~oe_n & ~ce_n & we_n;
  assign wait_out = r_wait;
  assign cfg_reg  = r_cfg;

endmodule

// File: tb/tb_cram_responder.sv
// Scoreboard bench for cram_responder: expected read data is queued when a read
// is issued and compared when the responder drives dq.
module tb_cram_responder;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned RL     = 4;
  localparam int unsigned WL     = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [5:0]  a;
  logic        adv_n, cre, ce_n, oe_n, we_n, ub_n, lb_n;
  logic        wait_out;
  logic [15:0] cfg_reg;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb_q [$];
  logic [15:0] model_mem [2**MEM_AW];
  logic [15:0] model_cfg;

  always #5 clk = ~clk;

  cram_responder #(
    .MEM_AW(MEM_AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL), .CFG_RESET(16'h9D1F)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .a(a), .adv_n(adv_n), .cre(cre), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
    .ub_n(ub_n), .lb_n(lb_n), .wait_out(wait_out), .cfg_reg(cfg_reg)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] byte_mask(input logic [15:0] v, input logic ub, input logic lb);
    return {ub ? 8'h00 : v[15:8], lb ? 8'h00 : v[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_n = 1'b1; adv_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; cre = 1'b0; a = '0; dq_in = '0;
  endtask

  task automatic addr_phase(input logic [21:0] ad, input logic c);
    ce_n = 1'b0; adv_n = 1'b0; a = ad[21:16]; dq_in = ad[15:0]; cre = c;
    step();
  endtask

  // Counts cycles with wait_out high; returns at the negedge of the first low cycle after.
  task automatic count_wait(output int n);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (wait_out) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic do_write(input string tag, input logic [21:0] ad, input logic [15:0] d,
                          input logic ub, input logic lb, input logic c);
    int n;
    addr_phase(ad, c);
    adv_n = 1'b1; we_n = 1'b0; dq_in = d; ub_n = ub; lb_n = lb;
    count_wait(n);
    check_eq({tag, "_wlat"}, 16'(n), 16'(WL));
    step();
    check_eq({tag, "_done_wait"}, 16'(wait_out), 16'h0);
    bus_idle();
    step();
    if (c) model_cfg = ad[15:0];
    else begin
      if (!ub) model_mem[ad[MEM_AW-1:0]][15:8] = d[15:8];
      if (!lb) model_mem[ad[MEM_AW-1:0]][7:0]  = d[7:0];
    end
  endtask

  task automatic start_read(input string tag, input logic [21:0] ad,
                            input logic ub, input logic lb, input logic c);
    int n;
    sb_q.push_back(byte_mask(c ? model_cfg : model_mem[ad[MEM_AW-1:0]], ub, lb));
    addr_phase(ad, c);
    adv_n = 1'b1; oe_n = 1'b0; ub_n = ub; lb_n = lb;
    count_wait(n);
    check_eq({tag, "_rlat"}, 16'(n), 16'(RL));
    check_eq({tag, "_oe"}, 16'(dq_oe), 16'h1);
    if (sb_q.size() == 0) check_eq({tag, "_sb_empty"}, 16'h1, 16'h0);
    else check_eq({tag, "_data"}, dq_out, sb_q.pop_front());
  endtask

  task automatic do_read(input string tag, input logic [21:0] ad,
                         input logic ub, input logic lb, input logic c);
    start_read(tag, ad, ub, lb, c);
    @(posedge clk);
    #1 oe_n = 1'b1;
    #1 check_eq({tag, "_release"}, 16'(dq_oe), 16'h0);
    bus_idle();
    step();
  endtask

  initial begin
    bus_idle();
    reset_n = 1'b0;
    model_cfg = 16'h9D1F;
    step();
    step();
    check_eq("rst_oe", 16'(dq_oe), 16'h0);
    check_eq("rst_wait", 16'(wait_out), 16'h0);
    check_eq("rst_cfg", cfg_reg, 16'h9D1F);
    check_eq("rst_dq", dq_out, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    step();

    do_write("wr_beef", 22'h000123, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    do_read("rd_beef", 22'h000123, 1'b0, 1'b0, 1'b0);

    do_write("wr_lb", 22'h000123, 16'h1234, 1'b1, 1'b0, 1'b0);
    do_read("rd_lb", 22'h000123, 1'b0, 1'b0, 1'b0);
    do_read("rd_ubmask", 22'h000123, 1'b1, 1'b0, 1'b0);

    do_write("wr_wrap", 22'h000400, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    do_read("rd_wrap", 22'h000000, 1'b0, 1'b0, 1'b0);

    do_write("wr_110", 22'h000110, 16'h7777, 1'b0, 1'b0, 1'b0);
    do_write("wr_cfg", 22'h008110, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    check_eq("cfg_val", cfg_reg, 16'h8110);
    do_read("rd_110", 22'h000110, 1'b0, 1'b0, 1'b0);
    do_read("rd_cfg", 22'h008110, 1'b0, 1'b0, 1'b1);

    // Abort a write on its second wait cycle.
    addr_phase(22'h000123, 1'b0);
    adv_n = 1'b1; we_n = 1'b0; dq_in = 16'h5555;
    step();
    step();
    check_eq("abort_busy", 16'(wait_out), 16'h1);
    ce_n = 1'b1; we_n = 1'b1;
    step();
    check_eq("abort_wait", 16'(wait_out), 16'h0);
    bus_idle();
    step();
    do_read("rd_abort", 22'h000123, 1'b0, 1'b0, 1'b0);

    // Reset while the responder is driving read data.
    start_read("rd_rst", 22'h000400, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_oe", 16'(dq_oe), 16'h0);
    check_eq("rst_mid_cfg", cfg_reg, 16'h9D1F);
    model_cfg = 16'h9D1F;
    bus_idle();
    @(negedge clk) reset_n = 1'b1;
    step();
    do_read("rd_persist", 22'h000123, 1'b0, 1'b0, 1'b0);
    do_read("rd_cfg_rst", 22'h000000, 1'b0, 1'b0, 1'b1);

    check_eq("sb_left", 16'(sb_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cram_responder.md
Name: cram_responder

Overview:
- Clocked responder for the cellular-RAM (PSRAM) pin interface: the device side of the bus our controller drives (address-muxed dq, adv_n, cre, ce_n, oe_n, we_n, ub_n/lb_n, wait).
- Backs a small word array and a bus configuration register.
- Used in simulation and on-FPGA loopback to exercise the controller without the physical chip.
- Samples all pins on its own clk, which runs much faster than pin activity; the bench drives pins synchronously to clk.

Parameters:
MEM_AW, 10, word-address bits of internal array; the full 22-bit word address wraps modulo 2**MEM_AW
READ_LATENCY, 4, clk cycles wait_out is held after a read access starts, before data drives (min 1)
WRITE_LATENCY, 3, clk cycles wait_out is held after a write access starts, before dq is sampled (min 1)
CFG_RESET, 16'h9D1F, reset value of configuration register

Ports:
clk  input  1  responder clock
reset_n  input  1  asynchronous active-low reset
dq_in  input  16  value currently on dq (address during adv_n low, write data otherwise)
dq_out  output  16  read data to drive onto dq
dq_oe  output  1  1 = responder drives dq
a  input  6  upper word address [21:16]
adv_n  input  1  address valid, active low
cre  input  1  1 = access targets configuration register
ce_n  input  1  chip enable, active low
oe_n  input  1  output enable, active low
we_n  input  1  write enable, active low
ub_n  input  1  upper-byte enable, active low
lb_n  input  1  lower-byte enable, active low
wait_out  output  1  1 = access not ready (device busy)
cfg_reg  output  16  current configuration register

Behaviour:
- Reset (async assert, sync release): state IDLE, dq_out=0, dq_oe=0, wait_out=0, cfg_reg=CFG_RESET, latched address=0, counter=0. Array contents are not cleared.
- States: IDLE, ADDR, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE.
- IDLE:
  - If ce_n=0 and adv_n=0: latch addr={a,dq_in} and cre_l=cre, then go to ADDR.
  - Otherwise stay.
- ADDR:
  - While adv_n=0: relatch addr and cre_l every cycle.
  - On the first cycle with adv_n=1:
    - we_n=0: go to WR_WAIT, counter=WRITE_LATENCY.
    - else oe_n=0: go to RD_WAIT, counter=READ_LATENCY.
    - else: stay in ADDR.
- RD_WAIT:
  - wait_out=1 and dq_oe=0; counter decrements each cycle.
  - When counter reaches 0, go to RD_DATA on the next edge.
  - The RD_WAIT entry cycle counts as one of the READ_LATENCY cycles.
- RD_DATA:
  - wait_out=0.
  - dq_out = cre_l ? cfg_reg : mem[addr mod 2**MEM_AW].
  - Bytes with ub_n/lb_n=1 read as 8'h00.
  - dq_oe = ~oe_n, combinational from registered state and the live oe_n, so the bus releases in the same cycle oe_n rises.
  - Stays until ce_n=1.
- WR_WAIT:
  - wait_out=1; counter decrements each cycle.
  - At counter 0, on the next cycle:
    - cre_l=0: write dq_in into the array, upper byte only if ub_n=0, lower byte only if lb_n=0.
    - cre_l=1: cfg_reg <= addr[15:0], device style; data and byte enables are ignored.
  - Then go to WR_DONE.
- WR_DONE: wait_out=0, no further writes; stays until ce_n=1.
- ce_n=1 in any state: next state IDLE, dq_oe=0 immediately (combinational), wait_out=0 next cycle, any pending write is abandoned with no array change.
- adv_n=0 outside IDLE/ADDR with ce_n=0: ignored; a new access requires ce_n high for at least one cycle.
- oe_n and we_n both low at the adv_n rising cycle: treated as a write.
- One access per ce_n assertion; no burst/sync mode. cfg_reg is stored and reported only and does not alter timing.
- Reset mid-access: immediate IDLE, dq_oe=0, written bytes up to that point persist.
- dq_oe must never be 1 while we_n=0.

Test Plan:
- Reset: hold reset_n=0 -> dq_oe=0, wait_out=0, cfg_reg=16'h9D1F; release -> state IDLE.
- Write then read 16'hBEEF at addr 22'h000123 (both bytes) -> wait_out high exactly 3 cycles on write; read shows wait_out high exactly 4 cycles, then dq_out=16'hBEEF, dq_oe=1 until oe_n rises.
- Byte enables: write 16'h1234 with lb_n=0, ub_n=1 over prior 16'hBEEF -> read returns 16'hBE34. Read with ub_n=1 -> 16'h0034.
- Wrap: write 16'hA5A5 to 22'h000400 (MEM_AW=10) -> read at 22'h000000 returns 16'hA5A5.
- Config: cre=1 write with address 16'h8110 -> cfg_reg=16'h8110, array unchanged. cre=1 read -> dq_out=16'h8110.
- Abort: deassert ce_n on the second WR_WAIT cycle -> wait_out low next cycle, array location unchanged. Assert reset_n=0 during RD_DATA -> dq_oe drops immediately.
